// File: rtl/mod_exp_engine.sv
// Constant-time modular exponentiation (left-to-right square-and-multiply)
// built on a bit-serial interleaved shift-add modular multiplier.
module mod_exp_engine #(
  parameter int N = 64,
  parameter int E = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   base,
  input  logic [E-1:0]   exponent,
  input  logic [N-1:0]   modulus,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [N-1:0]   result,
  output logic [127:0]   key_out
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int EW = (E > 1) ? $clog2(E) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(N - 1);
  localparam logic [EW-1:0] IDX_MAX = EW'(E - 1);

  typedef enum logic [1:0] {IDLE, SQR, MUL, FIN} state_t;

  state_t        state, state_next;
  logic [N-1:0]  base_r, mod_r, r_reg, acc, mcand, step;
  logic [E-1:0]  exp_r;
  logic [CW-1:0] cnt;
  logic [EW-1:0] idx;
  logic          err_pend;
  logic [N:0]    dbl, red1, sum;
  logic          bit_cur, last_bit, illegal;

  // One multiplier step: acc = 2*acc (+ mcand if bit) mod m, with acc < m kept
  always_comb begin
    mcand    = (state == SQR) ? r_reg : base_r;
    bit_cur  = r_reg[cnt];
    dbl      = {acc, 1'b0};
    red1     = (dbl >= {1'b0, mod_r}) ? dbl - {1'b0, mod_r} : dbl;
    sum      = red1 + {1'b0, (bit_cur ? mcand : '0)};
    step     = (sum >= {1'b0, mod_r}) ? N'(sum - {1'b0, mod_r}) : sum[N-1:0];
    last_bit = (cnt == '0);
    illegal  = (modulus < N'(2)) || (base >= modulus);
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    case (state)
      IDLE: if (start) state_next = illegal ? FIN : SQR;
      SQR: begin
        busy = 1'b1;
        if (last_bit) state_next = MUL;
      end
      MUL: begin
        busy = 1'b1;
        if (last_bit) state_next = (idx == '0) ? FIN : SQR;
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      base_r   <= '0;
      exp_r    <= '0;
      mod_r    <= '0;
      r_reg    <= '0;
      acc      <= '0;
      cnt      <= '0;
      idx      <= '0;
      err_pend <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      result   <= '0;
      key_out  <= '0;
    end else begin
      state <= state_next;
      done  <= 1'b0;
      case (state)
        IDLE: if (start) begin
          base_r   <= base;
          exp_r    <= exponent;
          mod_r    <= modulus;
          acc      <= '0;
          cnt      <= CNT_MAX;
          idx      <= IDX_MAX;
          err_pend <= illegal;
          r_reg    <= illegal ? '0 : N'(1);
        end
        SQR: begin
          if (last_bit) begin
            r_reg <= step;
            acc   <= '0;
            cnt   <= CNT_MAX;
          end else begin
            acc <= step;
            cnt <= cnt - CW'(1);
          end
        end
        MUL: begin
          if (last_bit) begin
            // product always computed; committed only for a set exponent bit
            if (exp_r[idx]) r_reg <= step;
            acc <= '0;
            cnt <= CNT_MAX;
            if (idx != '0) idx <= idx - EW'(1);
          end else begin
            acc <= step;
            cnt <= cnt - CW'(1);
          end
        end
        FIN: begin
          done    <= 1'b1;
          err     <= err_pend;
          result  <= r_reg;
          key_out <= 128'(r_reg);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_exp_engine.sv
// Bench for mod_exp_engine: directed vectors at N=64/E=16 plus random
// operands at N=8/E=8 against an arithmetic reference model.
module tb_mod_exp_engine;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start64 = 1'b0;
  logic [63:0]   base64 = '0, mod64 = '0;
  logic [15:0]   exp64 = '0;
  logic          busy64, done64, err64;
  logic [63:0]   result64;
  logic [127:0]  key64;

  logic          start8 = 1'b0;
  logic [7:0]    base8 = '0, mod8 = '0, exp8 = '0;
  logic          busy8, done8, err8;
  logic [7:0]    result8;
  logic [127:0]  key8;

  mod_exp_engine #(.N(64), .E(16)) dut64 (
    .clk(clk), .rst_n(rst_n), .start(start64), .base(base64), .exponent(exp64),
    .modulus(mod64), .busy(busy64), .done(done64), .err(err64),
    .result(result64), .key_out(key64));

  mod_exp_engine #(.N(8), .E(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .base(base8), .exponent(exp8),
    .modulus(mod8), .busy(busy8), .done(done8), .err(err8),
    .result(result8), .key_out(key8));

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  // right-to-left binary exponentiation with plain wide arithmetic
  function automatic logic [127:0] ref_modexp(input logic [127:0] b, input logic [127:0] e,
                                              input logic [127:0] m);
    logic [255:0] r, x;
    logic [127:0] k;
    r = 256'd1 % {128'd0, m};
    x = {128'd0, b} % {128'd0, m};
    k = e;
    while (k != 0) begin
      if (k[0]) r = (r * x) % {128'd0, m};
      x = (x * x) % {128'd0, m};
      k = k >> 1;
    end
    return r[127:0];
  endfunction

  // Launch one run on dut64 and watch a fixed window of edges.
  // pulse_at: edge at which a stray start is pulsed (0 = none)
  // rst_at:   edge at which rst_n is pulsed low (0 = none)
  task automatic run64(input logic [63:0] b, input logic [15:0] e, input logic [63:0] m,
                       input int pulse_at, input int rst_at,
                       output int lat, output int ndone, output bit busy_seen);
    @(negedge clk);
    base64 = b; exp64 = e; mod64 = m; start64 = 1'b1;
    @(posedge clk);
    #1;
    start64 = 1'b0; base64 = '1; exp64 = 16'hA5A5; mod64 = 64'd3;
    lat = -1; ndone = 0; busy_seen = busy64;
    for (int k = 1; k <= 2400; k++) begin
      @(posedge clk);
      #1;
      if (done64) begin
        ndone++;
        if (lat < 0) lat = k;
      end
      if (busy64) busy_seen = 1'b1;
      if (k == pulse_at) begin
        start64 = 1'b1; base64 = 64'd5; exp64 = 16'd3; mod64 = 64'd67;
      end else begin
        start64 = 1'b0;
      end
      if (k == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_busy", busy64, 0);
        chk("rst_done", done64, 0);
        chk("rst_err", err64, 0);
        chk("rst_result", result64, 0);
        chk("rst_key", key64, 0);
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
  endtask

  task automatic run8(input logic [7:0] b, input logic [7:0] e, input logic [7:0] m,
                      output int lat);
    @(negedge clk);
    base8 = b; exp8 = e; mod8 = m; start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0; base8 = 8'hFF; exp8 = ~e; mod8 = 8'd3;
    lat = 0;
    while (!done8 && lat < 400) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  typedef struct {
    logic [63:0] b;
    logic [15:0] e;
    logic [63:0] m;
    logic [63:0] want;
    bit          want_err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int lat, ndone;
    bit bs;
    logic [7:0] rb, re, rm;
    logic [127:0] want;

    vecs[0] = '{b: 64'd2,  e: 16'd15, m: 64'd67, want: 64'd5,  want_err: 1'b0};
    vecs[1] = '{b: 64'd5,  e: 16'd3,  m: 64'd67, want: 64'd58, want_err: 1'b0};
    vecs[2] = '{b: 64'd2,  e: 16'd5,  m: 64'd67, want: 64'd32, want_err: 1'b0};
    vecs[3] = '{b: 64'd9,  e: 16'd0,  m: 64'd67, want: 64'd1,  want_err: 1'b0};
    vecs[4] = '{b: 64'd0,  e: 16'd7,  m: 64'd1,  want: 64'd0,  want_err: 1'b1};
    vecs[5] = '{b: 64'd70, e: 16'd3,  m: 64'd67, want: 64'd0,  want_err: 1'b1};

    #2;
    chk("por_busy", busy64, 0);
    chk("por_done", done64, 0);
    chk("por_err", err64, 0);
    chk("por_result", result64, 0);
    chk("por_key", key64, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run64(vecs[i].b, vecs[i].e, vecs[i].m, 0, 0, lat, ndone, bs);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].want_err ? 1 : 2049);
      chk($sformatf("v%0d_ndone", i), ndone, 1);
      chk($sformatf("v%0d_result", i), result64, vecs[i].want);
      chk($sformatf("v%0d_key", i), key64, {64'd0, vecs[i].want});
      chk($sformatf("v%0d_err", i), err64, vecs[i].want_err);
      chk($sformatf("v%0d_busy_seen", i), bs, !vecs[i].want_err);
    end

    // stray start while busy is dropped
    run64(64'd2, 16'd15, 64'd67, 500, 0, lat, ndone, bs);
    chk("pulse_latency", lat, 2049);
    chk("pulse_ndone", ndone, 1);
    chk("pulse_result", result64, 5);

    // reset mid-run aborts without done
    run64(64'd2, 16'd15, 64'd67, 0, 1000, lat, ndone, bs);
    chk("abort_ndone", ndone, 0);
    chk("abort_result", result64, 0);
    run64(64'd2, 16'd15, 64'd67, 0, 0, lat, ndone, bs);
    chk("after_rst_latency", lat, 2049);
    chk("after_rst_result", result64, 5);
    chk("after_rst_err", err64, 0);

    // held start relaunches on the idle cycle after FIN
    @(negedge clk);
    base8 = 8'd3; exp8 = 8'd4; mod8 = 8'd7; start8 = 1'b1;
    lat = 0;
    @(posedge clk);
    #1;
    while (!done8 && lat < 400) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("held_first_latency", lat, 129);
    chk("held_first_result", result8, 4);
    @(posedge clk);
    #1;
    chk("held_relaunch_busy", busy8, 1);
    start8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 400) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("held_second_result", result8, 4);

    for (int i = 0; i < 200; i++) begin
      rm = 8'($urandom_range(2, 255));
      rb = 8'($urandom_range(0, int'(rm) - 1));
      re = 8'($urandom_range(0, 255));
      want = ref_modexp({120'd0, rb}, {120'd0, re}, {120'd0, rm});
      run8(rb, re, rm, lat);
      chk($sformatf("rnd%0d_latency b=%0d e=%0d m=%0d", i, rb, re, rm), lat, 129);
      chk($sformatf("rnd%0d_result b=%0d e=%0d m=%0d", i, rb, re, rm), result8, want);
      chk($sformatf("rnd%0d_key", i), key8, want);
      chk($sformatf("rnd%0d_err", i), err8, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
